// File: rtl/mem_pkg.sv
// Shared definitions for the I/D cache memory arbiter.
package mem_pkg;

    localparam int ADDR_W_DEF   = 28;
    localparam int BLOCK_W_DEF  = 128;
    localparam int MAX_WAIT_DEF = 255;

    // Requester ids; the round-robin picker relies on these being 0/1
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the side that did not win last time wins.
module rr_pick2
    import mem_pkg::*;
(
    input  logic ireq_i,
    input  logic dreq_i,
    input  logic last_i,
    output logic gnt_o,
    output logic vld_o
);

    // Tie goes to the id opposite to the last grant
    always_comb begin
        vld_o = ireq_i | dreq_i;
        if (ireq_i && dreq_i) begin
            gnt_o = ~last_i;
        end else if (dreq_i) begin
            gnt_o = REQ_D;
        end else begin
            gnt_o = REQ_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide memory port between the I-cache (refills) and the
// D-cache (refills and write-backs); one transaction in flight at a time.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BLOCK_W  = BLOCK_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT,
    output logic               ERROR
);

    // Watchdog counter is at least 8 bits wide
    localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    localparam logic [CNT_W-1:0] WMAX = CNT_W'(MAX_WAIT);

    arb_state_e         state_q;
    logic               gnt_q;
    logic               last_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [BLOCK_W-1:0] mem_wdata_q;
    logic [BLOCK_W-1:0] i_rdata_q;
    logic [BLOCK_W-1:0] d_rdata_q;
    logic [CNT_W-1:0]   wcnt_q;
    logic [CNT_W-1:0]   wcnt_d;
    logic               error_q;

    logic d_req;
    logic pick_gnt;
    logic pick_vld;

    // A simultaneous D_READ/D_WRITE is a write; either one is a D request
    assign d_req  = D_READ | D_WRITE;
    assign wcnt_d = wcnt_q + CNT_W'(1);

    rr_pick2 u_pick (
        .ireq_i (I_READ),
        .dreq_i (d_req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .vld_o  (pick_vld)
    );

    // Arbitration FSM, memory-side registers, read capture and watchdog
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            gnt_q       <= REQ_I;
            last_q      <= REQ_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            wcnt_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q  <= pick_gnt;
                        last_q <= pick_gnt;
                        wcnt_q <= '0;
                        if (pick_gnt == REQ_I) begin
                            state_q    <= GRANT_I;
                            mem_addr_q <= I_ADDRESS;
                            mem_read_q <= 1'b1;
                        end else begin
                            state_q    <= GRANT_D;
                            mem_addr_q <= D_ADDRESS;
                            if (D_WRITE) begin
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= D_WRITEDATA;
                            end else begin
                                mem_read_q <= 1'b1;
                            end
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!MEM_BUSYWAIT) begin
                        // Capture even if the requester already dropped its request
                        if (mem_read_q) begin
                            if (gnt_q == REQ_I) i_rdata_q <= MEM_READDATA;
                            else                d_rdata_q <= MEM_READDATA;
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= DONE;
                    end else if (wcnt_q != WMAX) begin
                        // Saturating busy count; the transaction keeps waiting
                        wcnt_q <= wcnt_d;
                        if (wcnt_d == WMAX) error_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Busywait drops only in the DONE cycle of the granted side; forced low in reset
    assign I_BUSYWAIT = RESETN & I_READ & ~((state_q == DONE) && (gnt_q == REQ_I));
    assign D_BUSYWAIT = RESETN & d_req  & ~((state_q == DONE) && (gnt_q == REQ_D));

    assign I_READDATA    = i_rdata_q;
    assign D_READDATA    = d_rdata_q;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign ERROR         = error_q;

endmodule
